// File: rtl/pixel_ingest_binarizer_pkg.sv
// Shared types and constants for the pixel ingest / binarizer block.
// Optional SOF restart checking is enabled with INGEST_SOF_CHECK_EN.
package ingest_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        WAIT = 2'd3
    } state_e;

    localparam logic PIX_FG = 1'b1;
    localparam logic PIX_BG = 1'b0;

    function automatic int frame_pixels(input int n);
        return n * n;
    endfunction

endpackage

// File: rtl/pixel_ingest_binarizer_if.sv
// Valid/ready pixel stream carrying a start-of-frame marker.
interface pixel_ingest_binarizer_if #(
    parameter int W = 8
);
    logic         s_valid;
    logic         s_sof;
    logic [W-1:0] s_data;
    logic         s_ready;

    modport master (
        output s_valid,
        output s_sof,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_sof,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/pixel_ingest_binarizer_thresholder.sv
// Registered compare stage: one write strobe per accepted pixel.
module pixel_thresholder
    import ingest_pkg::*;
#(
    parameter int           W  = 8,
    parameter logic [W-1:0] FG = {W{PIX_FG}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr,
    input  logic [W-1:0] i_pix,
    input  logic [W-1:0] i_thr,
    output logic         o_we,
    output logic [W-1:0] o_data
);
    logic         r_we;
    logic [W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we   <= 1'b0;
            r_data <= {W{PIX_BG}};
        end else begin
            r_we <= i_wr;
            if (i_wr)
                r_data <= (i_pix >= i_thr) ? FG : {W{PIX_BG}};
        end
    end

    assign o_we   = r_we;
    assign o_data = r_data;
endmodule

// File: rtl/pixel_ingest_binarizer.sv
// Frame loader: binarizes N*N pixels, then waits for proc_done.
// Define INGEST_SOF_CHECK_EN to restart a frame on SOF during LOAD.
module pixel_ingest_binarizer
    import ingest_pkg::*;
#(
    parameter int                    N          = 8,
    parameter int                    bitSize    = 6,
    parameter int                    pixelWidth = 8,
    parameter logic [pixelWidth-1:0] FG_VALUE   = {pixelWidth{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pixel_ingest_binarizer_if.slave s,
    input  logic [pixelWidth-1:0] threshold,
    input  logic                  proc_done,
    output logic                  we,
    output logic [pixelWidth-1:0] data_out,
    output logic [bitSize:0]      pix_cnt,
    output logic                  frame_done,
`ifdef INGEST_SOF_CHECK_EN
    output logic                  sof_err,
`endif
    output logic                  busy
);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LOAD = LOAD;
    localparam logic [1:0] ST_DONE = DONE;
    localparam logic [1:0] ST_WAIT = WAIT;

    localparam logic [bitSize:0] FRAME_CNT =
        (bitSize+1)'(frame_pixels(N));

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_ready;
    logic [bitSize:0]      r_cnt;
    logic [bitSize:0]      w_cnt_nxt;
    logic [pixelWidth-1:0] r_thr;
    logic [pixelWidth-1:0] w_thr_use;
    logic                  w_acc;
    logic                  w_restart;
    logic                  w_sof_acc;
    logic                  w_wr;

    assign w_acc = s.s_valid && r_ready;

`ifdef INGEST_SOF_CHECK_EN
    logic r_sof_err;
    assign w_restart = w_acc && s.s_sof && (r_state == ST_LOAD);
    assign sof_err   = r_sof_err;
`else
    assign w_restart = 1'b0;
`endif

    assign w_sof_acc = (w_acc && s.s_sof && (r_state == ST_IDLE))
                     || w_restart;
    assign w_wr      = w_sof_acc || (w_acc && (r_state == ST_LOAD));
    // The SOF pixel is judged against the threshold it brings with it.
    assign w_thr_use = w_sof_acc ? threshold : r_thr;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_sof_acc) begin
                    w_cnt_nxt   = (bitSize+1)'(1);
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_restart) begin
                    w_cnt_nxt = (bitSize+1)'(1);
                end else if (w_acc) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt + 1'b1 == FRAME_CNT)
                        w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (proc_done) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_cnt   <= '0;
            r_thr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_IDLE)
                    || (w_state_nxt == ST_LOAD);
            r_cnt   <= w_cnt_nxt;
            if (w_sof_acc)
                r_thr <= threshold;
        end
    end

`ifdef INGEST_SOF_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sof_err <= 1'b0;
        else
            r_sof_err <= w_restart;
    end
`endif

    pixel_thresholder #(
        .W  (pixelWidth),
        .FG (FG_VALUE)
    ) u_thr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_wr   (w_wr),
        .i_pix  (s.s_data),
        .i_thr  (w_thr_use),
        .o_we   (we),
        .o_data (data_out)
    );

    assign s.s_ready  = r_ready;
    assign pix_cnt    = r_cnt;
    assign frame_done = (r_state == ST_DONE);
    assign busy       = (r_state == ST_DONE) || (r_state == ST_WAIT);
endmodule

// File: tb/tb_pixel_ingest_binarizer.sv
// Randomized bench with a frame-level reference model for pixel_ingest_binarizer.
// Build with INGEST_SOF_CHECK_EN to exercise the SOF restart path.
module tb_pixel_ingest_binarizer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] threshold = 8'd0;
    logic       proc_done = 1'b0;
    logic       we;
    logic [7:0] data_out;
    logic [6:0] pix_cnt;
    logic       frame_done;
    logic       busy;
`ifdef INGEST_SOF_CHECK_EN
    logic       sof_err;
    localparam bit SOFCHK = 1'b1;
`else
    localparam bit SOFCHK = 1'b0;
`endif

    always #5 clk = ~clk;

    pixel_ingest_binarizer_if #(.W(8)) sif ();

    pixel_ingest_binarizer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s          (sif),
        .threshold  (threshold),
        .proc_done  (proc_done),
        .we         (we),
        .data_out   (data_out),
        .pix_cnt    (pix_cnt),
        .frame_done (frame_done),
`ifdef INGEST_SOF_CHECK_EN
        .sof_err    (sof_err),
`endif
        .busy       (busy)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: phase 0=idle, 1=loading, 2=frame just completed, 3=waiting
    int         ph = 0;
    int         m_cnt = 0;
    logic [7:0] m_thr = 8'd0;
    bit         m_ready = 1'b0;
    bit         e_we = 1'b0;
    bit         e_fd = 1'b0;
    bit         e_busy = 1'b0;
    bit         e_err = 1'b0;
    logic [7:0] e_data = 8'd0;
    int         obs_we = 0;
    int         obs_ff = 0;
    int         obs_fd = 0;
    int         obs_err = 0;

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            ph = 0; m_cnt = 0; m_thr = 8'd0; m_ready = 1'b0;
            e_we = 1'b0; e_fd = 1'b0; e_busy = 1'b0; e_err = 1'b0;
        end else begin
            acc  = sif.s_valid && m_ready;
            e_we = 1'b0;
            e_err = 1'b0;
            if (ph == 0) begin
                if (acc && sif.s_sof) begin
                    m_thr = threshold;
                    e_we = 1'b1;
                    e_data = (sif.s_data >= m_thr) ? 8'hFF : 8'h00;
                    m_cnt = 1;
                    ph = 1;
                end
            end else if (ph == 1) begin
                if (acc) begin
                    if (SOFCHK && sif.s_sof) begin
                        m_thr = threshold;
                        m_cnt = 1;
                        e_err = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                    e_we = 1'b1;
                    e_data = (sif.s_data >= m_thr) ? 8'hFF : 8'h00;
                    if (m_cnt == 64) ph = 2;
                end
            end else if (ph == 2) begin
                ph = 3;
            end else if (proc_done) begin
                ph = 0;
                m_cnt = 0;
            end
            m_ready = (ph < 2);
            e_fd    = (ph == 2);
            e_busy  = (ph >= 2);
        end
        #1;
        chk("we", int'(we), int'(e_we));
        chk("s_ready", int'(sif.s_ready), int'(m_ready));
        chk("pix_cnt", int'(pix_cnt), m_cnt);
        chk("frame_done", int'(frame_done), int'(e_fd));
        chk("busy", int'(busy), int'(e_busy));
        if (e_we) chk("data_out", int'(data_out), int'(e_data));
`ifdef INGEST_SOF_CHECK_EN
        chk("sof_err", int'(sof_err), int'(e_err));
        if (sof_err) obs_err++;
`endif
        if (we) obs_we++;
        if (we && data_out == 8'hFF) obs_ff++;
        if (frame_done) obs_fd++;
    end

    task automatic send(input logic [7:0] d, input bit sof, input logic [7:0] thr);
        bit ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            sif.s_valid = 1'b1;
            sif.s_sof   = sof;
            sif.s_data  = d;
            threshold   = thr;
            proc_done   = 1'b0;
            if (sif.s_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sif.s_valid = 1'b0;
            sif.s_sof   = 1'b0;
            proc_done   = 1'b0;
        end
    endtask

    task automatic pulse_done();
        @(negedge clk);
        sif.s_valid = 1'b0;
        sif.s_sof   = 1'b0;
        proc_done   = 1'b1;
        @(negedge clk);
        proc_done   = 1'b0;
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 64; i++)
            send(8'($urandom_range(0, 255)), i == 0, 8'($urandom_range(0, 255)));
    endtask

    initial begin
        int b_we, b_ff, b_fd, b_err;
        sif.s_valid = 1'b0;
        sif.s_sof   = 1'b0;
        sif.s_data  = 8'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_we", int'(we), 0);
        chk("rst_ready", int'(sif.s_ready), 0);
        chk("rst_cnt", int'(pix_cnt), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_data", int'(data_out), 0);
        rst_n = 1'b1;

        // Nominal frame, threshold 128, values i*4
        b_we = obs_we; b_ff = obs_ff; b_fd = obs_fd;
        for (int i = 0; i < 64; i++)
            send(8'(i * 4), i == 0, 8'd128);
        idle(3);
        chk("nom_writes", obs_we - b_we, 64);
        chk("nom_fg", obs_ff - b_ff, 32);
        chk("nom_fd", obs_fd - b_fd, 1);
        chk("nom_cnt", int'(pix_cnt), 64);
        chk("nom_ready", int'(sif.s_ready), 0);

        // Backpressure while waiting for proc_done
        b_we = obs_we;
        repeat (20) begin
            @(negedge clk);
            sif.s_valid = 1'b1;
            sif.s_sof   = 1'($urandom_range(0, 1));
            sif.s_data  = 8'($urandom_range(0, 255));
        end
        chk("bp_writes", obs_we - b_we, 0);
        pulse_done();
        chk("bp_ready", int'(sif.s_ready), 1);
        chk("bp_cnt", int'(pix_cnt), 0);

        // Pre-SOF drop, threshold latched at SOF only
        b_we = obs_we; b_ff = obs_ff;
        repeat (3) send(8'hFF, 1'b0, 8'h00);
        send(8'h20, 1'b1, 8'h10);
        for (int i = 1; i < 64; i++)
            send(8'($urandom_range(0, 255)), 1'b0, 8'hF0);
        idle(3);
        chk("drop_writes", obs_we - b_we, 64);
        chk("drop_first_fg", obs_ff - b_ff >= 1 ? 1 : 0, 1);
        pulse_done();

        // Stalls, with ignored proc_done pulses during LOAD
        b_we = obs_we; b_fd = obs_fd;
        for (int i = 0; i < 64; i++) begin
            send(8'($urandom_range(0, 255)), i == 0, 8'($urandom_range(0, 255)));
            @(negedge clk);
            sif.s_valid = 1'b0;
            proc_done   = (i % 7 == 3);
        end
        idle(3);
        chk("stall_writes", obs_we - b_we, 64);
        chk("stall_fd", obs_fd - b_fd, 1);
        pulse_done();

        // Asynchronous reset mid-frame
        for (int i = 0; i < 30; i++)
            send(8'($urandom_range(0, 255)), i == 0, 8'($urandom_range(0, 255)));
        @(negedge clk);
        sif.s_valid = 1'b0;
        chk("pre_rst_we", int'(we), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_we", int'(we), 0);
        chk("arst_ready", int'(sif.s_ready), 0);
        chk("arst_cnt", int'(pix_cnt), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        b_we = obs_we; b_fd = obs_fd;
        rand_frame();
        idle(3);
        chk("post_rst_writes", obs_we - b_we, 64);
        chk("post_rst_fd", obs_fd - b_fd, 1);
        pulse_done();

        // SOF arriving at pixel 40 of a frame
        b_we = obs_we; b_fd = obs_fd; b_err = obs_err;
        for (int i = 0; i < 40; i++)
            send(8'($urandom_range(0, 255)), i == 0, 8'($urandom_range(0, 255)));
        send(8'($urandom_range(0, 255)), 1'b1, 8'($urandom_range(0, 255)));
        idle(1);
`ifdef INGEST_SOF_CHECK_EN
        chk("restart_cnt", int'(pix_cnt), 1);
        chk("restart_err", int'(sof_err), 1);
        for (int i = 0; i < 63; i++)
            send(8'($urandom_range(0, 255)), 1'b0, 8'($urandom_range(0, 255)));
        idle(3);
        chk("restart_err_cnt", obs_err - b_err, 1);
        chk("restart_writes", obs_we - b_we, 104);
`else
        chk("mid_sof_cnt", int'(pix_cnt), 41);
        for (int i = 0; i < 23; i++)
            send(8'($urandom_range(0, 255)), 1'b0, 8'($urandom_range(0, 255)));
        idle(3);
        chk("mid_sof_err_cnt", obs_err - b_err, 0);
        chk("mid_sof_writes", obs_we - b_we, 64);
`endif
        chk("sof_fd", obs_fd - b_fd, 1);
        pulse_done();
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pixel_ingest_binarizer.md
Name: pixel_ingest_binarizer

Overview:
- Upstream feeder for the skeletonization controller.
- Accepts a raster-order grayscale pixel stream over a valid/ready handshake and thresholds each pixel to binary foreground/background.
- Drives the controller's write enable and pixel data for exactly N*N pixels per frame.
- Holds off further input until the downstream skeletonization pass reports completion.

Parameters:
- N, 8, image side length; one frame is N*N pixels.
- bitSize, 6, address width minus one; the pixel counter is bitSize+1 bits, matching the downstream address counter.
- pixelWidth, 8, width of input and output pixels.
- FG_VALUE, all ones ({pixelWidth{1'b1}}), value written for a foreground pixel; background is 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  upstream pixel valid.
- s_sof  in  1  start-of-frame marker, qualified by s_valid.
- s_data  in  pixelWidth  upstream grayscale pixel.
- s_ready  out  1  block can accept a pixel this cycle.
- threshold  in  pixelWidth  binarization threshold, sampled at SOF acceptance.
- proc_done  in  1  one-cycle pulse from downstream: skeleton pass finished.
- we  out  1  write enable to the controller (its we input).
- data_out  out  pixelWidth  binarized pixel to the controller (its data_in input).
- pix_cnt  out  bitSize+1  number of pixels accepted in the current frame.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- busy  out  1  high from frame completion until proc_done.

Behaviour:
- Reset values (asynchronous, immediate on rst_n low): state IDLE, we=0, data_out=0, s_ready=0, pix_cnt=0, frame_done=0, busy=0, latched threshold=0. s_ready rises the first cycle after rst_n deasserts.
- Accept means s_valid && s_ready on a rising edge.
- Binarize with the latched threshold: data_out = (s_data >= thr_q) ? FG_VALUE : 0. Comparison is unsigned.
- Latency is 1 cycle: a pixel accepted at edge t gives we=1 and data_out valid for the cycle after t. we is 0 in every other cycle, so it is never high on two consecutive cycles unless accepts are back-to-back.
- State IDLE:
  - s_ready=1.
  - An accept with s_sof=1 latches threshold (the SOF pixel itself uses the new value), writes that pixel, sets pix_cnt=1, and goes to LOAD.
  - An accept with s_sof=0 is consumed and dropped: no we, pix_cnt unchanged.
- State LOAD:
  - s_ready=1.
  - Each accept writes the pixel and increments pix_cnt.
  - s_sof in LOAD is treated as an ordinary pixel when the optional feature is off.
  - The accept that makes pix_cnt reach N*N goes to DONE.
- State DONE (1 cycle): s_ready=0, frame_done=1, busy=1; then go to WAIT.
- State WAIT:
  - s_ready=0, busy=1, pix_cnt holds N*N.
  - proc_done=1 goes to IDLE, clearing pix_cnt and busy.
- proc_done in IDLE, LOAD, or DONE is ignored.
- Gaps: s_valid low in LOAD stalls without timeout and keeps the state.
- N*N equals 2^bitSize, so pix_cnt needs bitSize+1 bits; it never wraps because the frame ends at N*N.
- Reset mid-frame: partial frame discarded, outputs at reset values. The downstream counter is not reset by this block.

Optional Feature:
- Macro: INGEST_SOF_CHECK_EN.
- Defined:
  - An accept with s_sof=1 while in LOAD aborts the partial frame.
  - Adds output sof_err (1 bit, reset 0), which pulses for 1 cycle on the write cycle of that pixel.
  - The pixel restarts the frame: threshold re-latched, pixel written, pix_cnt=1.
- Undefined: sof_err port absent; s_sof ignored outside IDLE.

Decomposition:
- Package ingest_pkg:
  - state enum {IDLE, LOAD, DONE, WAIT}, 2 bits.
  - FG/BG value constants.
  - Helper function frame_pixels(N) = N*N.
- Sub-module: pixel_thresholder, a registered compare stage producing we/data_out from the accept strobe, pixel, and latched threshold. Instanced once.
- The FSM and counter stay in the top.

Test Plan:
- Reset then nominal frame: N=8, threshold=128, 64 back-to-back pixels with values i*4 (SOF on i=0) -> we high 64 consecutive cycles starting 1 cycle after the first accept; data_out=0 for i<32 and 0xFF for i>=32; frame_done pulses once with pix_cnt=64; s_ready=0 afterward.
- Backpressure hold: after the frame, drive s_valid=1 for 20 cycles, then pulse proc_done -> no accepts, no we; s_ready=1 one cycle after proc_done; pix_cnt=0.
- Pre-SOF drop and threshold latch: 3 pixels of 0xFF without SOF, then SOF with threshold=0x10; change threshold to 0xF0 mid-frame -> first 3 produce no we; all frame pixels are compared against 0x10.
- Stalls: s_valid toggling 1/0 through a frame -> exactly 64 we pulses, each 1 cycle after its accept; frame_done after the 64th.
- Async reset at pixel 30 -> we, s_ready, pix_cnt drop immediately; a fresh SOF frame then completes normally with 64 writes.
- With INGEST_SOF_CHECK_EN: SOF at pixel 40 -> sof_err pulses 1 cycle; pix_cnt=1; 63 more pixels needed before frame_done.
